// File: rtl/alu_div32.sv
// alu_div32: 32-bit iterative restoring divider, quotient on out, remainder on out0.
// Optional macro ALU_DIV_SIGNED_EN: op1[0] selects signed (truncating) division;
// without it all division is unsigned and op1 is ignored.
module alu_div32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  op1,
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  output logic        busy,
  output logic        done,
  output logic [31:0] out,
  output logic [31:0] out0,
  output logic        zero,
  output logic        N,
  output logic        overflow
);

  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2;

  logic [1:0]  state, state_nxt;
  logic [5:0]  cnt;
  logic [31:0] quo, rem, dvs;
  logic        dz, sov;
  logic        accept, dz_in, sov_in;
  logic [31:0] a_mag, b_mag, q_fin, r_fin, res_q, res_r;
  logic [32:0] shifted, diff;
  logic        unused_op1;

  assign unused_op1 = ^op1;
  assign accept     = (state == IDLE) && start;
  assign dz_in      = (in1 == 32'd0);

`ifdef ALU_DIV_SIGNED_EN
  logic sgn, neg_q, neg_r;
  assign sgn    = op1[0];
  assign a_mag  = (sgn && in0[31]) ? -in0 : in0;
  assign b_mag  = (sgn && in1[31]) ? -in1 : in1;
  assign sov_in = sgn && (in0 == 32'h8000_0000) && (in1 == 32'hFFFF_FFFF);
  assign q_fin  = neg_q ? -quo : quo;
  assign r_fin  = neg_r ? -rem : rem;

  // capture result signs with the operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= sgn && (in0[31] ^ in1[31]);
      neg_r <= sgn && in0[31];
    end
  end
`else
  assign a_mag  = in0;
  assign b_mag  = in1;
  assign sov_in = 1'b0;
  assign q_fin  = quo;
  assign r_fin  = rem;
`endif

  // one restoring step: shift next dividend bit into the partial remainder
  assign shifted = {rem, quo[31]};
  assign diff    = shifted - {1'b0, dvs};

  // final values; bypass cases override the iterative result
  always_comb begin
    res_q = q_fin;
    res_r = r_fin;
    if (dz) begin
      res_q = 32'hFFFF_FFFF;
      res_r = quo;               // raw dividend kept in quo on divide-by-zero
    end else if (sov) begin
      res_q = 32'h8000_0000;
      res_r = 32'd0;
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic; exceptional cases skip the iterations
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (dz_in || sov_in) ? FIX : CALC;
      CALC:    if (cnt == 6'd31) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state != IDLE);
  end

  // operand capture and shift-subtract iterations
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 6'd0;
      quo <= 32'd0;
      rem <= 32'd0;
      dvs <= 32'd0;
      dz  <= 1'b0;
      sov <= 1'b0;
    end else if (accept) begin
      cnt <= 6'd0;
      rem <= 32'd0;
      dvs <= b_mag;
      quo <= dz_in ? in0 : a_mag;
      dz  <= dz_in;
      sov <= sov_in;
    end else if (state == CALC) begin
      cnt <= cnt + 6'd1;
      if (!diff[32]) begin
        rem <= diff[31:0];
        quo <= {quo[30:0], 1'b1};
      end else begin
        rem <= shifted[31:0];
        quo <= {quo[30:0], 1'b0};
      end
    end
  end

  // result registers update together in FIX and hold until the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done     <= 1'b0;
      out      <= 32'd0;
      out0     <= 32'd0;
      zero     <= 1'b0;
      N        <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= (state == FIX);
      if (state == FIX) begin
        out      <= res_q;
        out0     <= res_r;
        zero     <= (res_q == 32'd0);
        N        <= res_q[31];
        overflow <= dz | sov;
      end
    end
  end

endmodule

// File: tb/tb_alu_div32.sv
// Self-checking bench for alu_div32 against an arithmetic reference model.
module tb_alu_div32;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op1 = 4'd0;
  logic [31:0] in0 = 32'd0, in1 = 32'd0;
  logic        busy, done, zero, N, overflow;
  logic [31:0] out, out0;

  int checks = 0;
  int errors = 0;

  alu_div32 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op1(op1), .in0(in0), .in1(in1),
    .busy(busy), .done(done), .out(out), .out0(out0), .zero(zero), .N(N),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference: truncating division with the two defined exception cases
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic ov, output int lat);
    bit sgn;
`ifdef ALU_DIV_SIGNED_EN
    sgn = op[0];
`else
    sgn = 1'b0;
`endif
    if (b == 0) begin
      q = 32'hFFFF_FFFF; r = a; ov = 1'b1; lat = 1;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 0; ov = 1'b1; lat = 1;
    end else if (sgn) begin
      int sa, sb;
      sa = a; sb = b;
      q = sa / sb; r = sa % sb; ov = 1'b0; lat = 33;
    end else begin
      q = a / b; r = a % b; ov = 1'b0; lat = 33;
    end
  endfunction

  // wait for done after the accepting edge; returns edges counted, 0 on timeout
  task automatic wait_done(input bit noise, output int n);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (done === 1'b1) start = 1'b0;
      else if (noise) begin
        start = 1'($urandom); in0 = $urandom; in1 = $urandom; op1 = 4'($urandom);
      end
    end
    if (n >= 100) n = 0;
  endtask

  task automatic check_result(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] op, input int n);
    logic [31:0] q, r; logic ov; int lat;
    model(a, b, op, q, r, ov, lat);
    check({tag, ".lat"}, n, lat);
    check({tag, ".out"}, out, q);
    check({tag, ".out0"}, out0, r);
    check({tag, ".zero"}, zero, (q == 0));
    check({tag, ".N"}, N, q[31]);
    check({tag, ".ovf"}, overflow, ov);
  endtask

  // one complete operation starting #1 after a rising edge
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input bit noise);
    int n;
    start = 1'b1; in0 = a; in1 = b; op1 = op;
    @(posedge clk); #1;
    check({tag, ".busy"}, busy, 1'b1);
    start = 1'b0; in0 = $urandom; in1 = $urandom; op1 = 4'($urandom);
    if (done === 1'b1) n = 1;
    else wait_done(noise, n);
    check_result(tag, a, b, op, n);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, done, 1'b0);
    check({tag, ".idle"}, busy, 1'b0);
  endtask

  initial begin
    int n, cnt;
    logic [31:0] a, b;
    logic [3:0] op;

    #1;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.out", out, 0);
    check("rst.out0", out0, 0);
    check("rst.flags", {zero, N, overflow}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("u100_7", 100, 7, 4'd0, 1'b0);
    run_op("div0", 5, 0, 4'd1, 1'b0);
    run_op("noise_busy", 32'd1000, 32'd3, 4'd0, 1'b1);
    run_op("u_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 4'd0, 1'b0);
`ifdef ALU_DIV_SIGNED_EN
    run_op("s_m100_7", 32'hFFFF_FF9C, 7, 4'd1, 1'b0);
    run_op("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 4'd1, 1'b0);
    run_op("s_neg_div", 32'd100, 32'hFFFF_FFF9, 4'd1, 1'b0);
`endif

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case (i % 4)
        0: b = 32'($urandom_range(1, 255));
        1: b = $urandom;
        2: b = (i % 8 == 2) ? 32'd0 : 32'($urandom_range(1, 65535));
        default: b = a >> $urandom_range(0, 31);
      endcase
      if (b == 0 && i % 8 != 2) b = 1;
      op = 4'($urandom);
      run_op($sformatf("rnd%0d", i), a, b, op, 1'b0);
    end

    // reset mid-operation abandons it
    start = 1'b1; in0 = 32'd77; in1 = 32'd5; op1 = 4'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst.busy", busy, 0);
    check("mid_rst.done", done, 0);
    check("mid_rst.out", out, 0);
    check("mid_rst.out0", out0, 0);
    check("mid_rst.flags", {zero, N, overflow}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) cnt++;
    end
    check("mid_rst.no_done", cnt, 0);

    // back-to-back: start held through the done cycle
    start = 1'b1; in0 = 32'd12345; in1 = 32'd67; op1 = 4'd0;
    @(posedge clk); #1;
    in0 = 32'd999; in1 = 32'd10;
    n = 0;
    while (done !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    check_result("b2b1", 32'd12345, 32'd67, 4'd0, n);
    // start stays high here so the done cycle accepts the second op
    @(posedge clk); #1;
    start = 1'b0; in0 = $urandom; in1 = $urandom;
    n = 1;
    while (done !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    check("b2b.spacing", n, 34);
    check_result("b2b2", 32'd999, 32'd10, 4'd0, n - 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_div32.md
ALU_DIV32 -- requirements
Module: alu_div32

Interface
REQ-001: The module SHALL have one clock, clk, and an asynchronous active-low reset, rst_n; all state is clocked on the rising edge of clk.
REQ-002: clk  input  1  system clock.
REQ-003: rst_n  input  1  asynchronous active-low reset.
REQ-004: start  input  1  request pulse; sampled only in IDLE.
REQ-005: op1  input  4  sub-op; bit0=1 signed, bit0=0 unsigned; bits[3:1] reserved and ignored.
REQ-006: in0  input  32  dividend.
REQ-007: in1  input  32  divisor.
REQ-008: busy  output  1  high while state is not IDLE.
REQ-009: done  output  1  one-cycle result-valid pulse.
REQ-010: out  output  32  quotient.
REQ-011: out0  output  32  remainder.
REQ-012: zero  output  1  quotient == 0.
REQ-013: N  output  1  quotient bit 31.
REQ-014: overflow  output  1  divide-by-zero or signed overflow occurred.

Function
REQ-015: States SHALL be IDLE, CALC and FIX; IDLE->CALC on accepted start; CALC->FIX after 32 iterations; FIX->IDLE after one cycle.
REQ-016: A start SHALL be accepted on rising edge E only when state is IDLE; in0, in1 and op1 are latched at E and may change afterwards.
REQ-017: A start SHALL be ignored while busy=1.
REQ-018: CALC SHALL perform one restoring shift-subtract iteration per cycle on operand magnitudes (edges E+1..E+32), using a 6-bit iteration counter.
REQ-019: At edge E+33 (FIX) out, out0, zero, N and overflow SHALL be registered together, done SHALL go high for exactly one cycle, and state SHALL return to IDLE.
REQ-020: Quotient sign SHALL be sign(in0) XOR sign(in1) and remainder sign SHALL equal sign(in0) (truncating division) when signed.
REQ-021: Divisor zero SHALL bypass CALC (E->FIX, done after edge E+1) with out=32'hFFFFFFFF, out0=in0, overflow=1.
REQ-022: Signed 32'h80000000 / 32'hFFFFFFFF SHALL bypass CALC (done after edge E+1) with out=32'h80000000, out0=0, overflow=1.
REQ-023: In all other cases overflow SHALL be 0.
REQ-024: out, out0, zero, N and overflow SHALL hold their last values until the next done, including while a new operation is busy.
REQ-025: A start asserted in the cycle where done=1 SHALL be accepted (state is IDLE).

Reset
REQ-026: rst_n low SHALL immediately force state IDLE, counter 0, busy=0, done=0, out=0, out0=0, zero=0, N=0, overflow=0.
REQ-027: Reset asserted mid-operation SHALL abandon the operation with no subsequent done pulse.

Configuration
REQ-028: With ALU_DIV_SIGNED_EN defined, op1[0] SHALL select signed division per REQ-020 and REQ-022.
REQ-029: Without ALU_DIV_SIGNED_EN, op1 SHALL be ignored, all division SHALL be unsigned, REQ-022 SHALL not apply, and no sign-correction logic SHALL be built.

Verification
REQ-030: Unsigned 100/7, start at edge E -> busy=1 from E, done=1 only between E+33 and E+34, out=14, out0=2, zero=0, N=0, overflow=0.
REQ-031: Signed (macro on) in0=-100 (32'hFFFFFF9C), in1=7 -> out=32'hFFFFFFF2, out0=32'hFFFFFFFE, N=1, overflow=0.
REQ-032: in0=5, in1=0 -> done after edge E+1, out=32'hFFFFFFFF, out0=5, overflow=1; second start during busy ignored.
REQ-033: in0=32'h80000000, in1=32'hFFFFFFFF: signed -> out=32'h80000000, out0=0, overflow=1, N=1; unsigned -> out=0, out0=32'h80000000, zero=1, overflow=0, done at E+33.
REQ-034: rst_n low 10 cycles after start -> busy=0, done=0, all outputs 0 immediately; no done pulse within the following 40 cycles.
REQ-035: Back-to-back: start held high through done cycle -> second operation accepted in the done cycle, its done exactly 34 cycles after the first done.
